turbo_asic_avalon: RTL and testbench
====================================

// Module: turbo_asic_avalon
// PURPOSE
// - Bridges an Avalon-ST word stream to the pins of the turbo-decoder test ASIC (7-bit soft input, control pins, result pins).
// - Per accepted input word: drives the ASIC pins, issues one ASIC_Clock pulse, samples the ASIC outputs into a packet buffer.
// - At the end of a packet, streams the result words out as one Avalon-ST packet. Every word carries the packet's bit-error count.
// - Sits between the host source/sink streams and the ASIC pads.
// PARAMETERS
// - DATA_WIDTH  32   Avalon-ST data width (bit map below assumes 32).
// - BUF_DEPTH   256  Result buffer depth in words. Must be >= packet length; the standard packet is 202 words.
// - CNT_WIDTH   7    Error counter width; counter saturates.
// PORTS
// - clk               in   1   single clock for all logic
// - reset             in   1   synchronous, active-high reset
// - asi_data          in   32  sink data
// - asi_valid         in   1   sink valid
// - asi_ready         out  1   sink ready
// - asi_sop           in   1   sink start of packet
// - asi_eop           in   1   sink end of packet
// - aso_data          out  32  source data
// - aso_valid         out  1   source valid
// - aso_ready         in   1   source ready
// - aso_sop           out  1   source start of packet
// - aso_eop           out  1   source end of packet
// - switch_fpga_asic  in   1   result channel select: 1 = channel 1, 0 = channel 2
// - ASIC_nReset, ASIC_Clock, ASIC_Go, ASIC_Mode  out 1 each  ASIC control pins
// - ASIC_Enable_f, ASIC_Sel_f, ASIC_S1, ASIC_S2, ASIC_S3  out 1 each  ASIC config pins
// - ASIC_In           out  7   ASIC soft-input sample
// - ASIC_DOut1, ASIC_DOut2, ASIC_TOut  in 7 each  ASIC data outputs
// - ASIC_bitout1, ASIC_bitout2, ASIC_KeepShift, ASIC_Start, ASIC_Start2, ASIC_TestReady, ASIC_Dclk  in 1 each  ASIC status pins
// BEHAVIOUR
// - Reset: all outputs 0 except ASIC_nReset; ASIC_nReset = ~reset (registered). Buffer index and error count are cleared. State = FILL.
// - Input word map:
//   - [6:0] -> ASIC_In; [8] -> ASIC_Go; [9] -> S3; [10] -> S2; [11] -> S1; [12] -> Sel_f; [13] -> Enable_f; [14] -> ASIC_Mode.
//   - [24]/[25] mirror sop/eop and are ignored; the asi_sop/asi_eop ports are authoritative.
// - FSM, states FILL -> CLK_HI -> SAMPLE -> (FILL | DRAIN):
//   - FILL: asi_ready=1. A word is accepted when asi_valid & asi_ready.
//     - sop word: opens a packet and clears the buffer index and error count.
//     - Word with no packet open: accepted and dropped; no ASIC activity.
//     - Otherwise: pins are registered from the word; next state CLK_HI.
//   - CLK_HI: ASIC_Clock=1 for exactly one cycle; asi_ready=0.
//   - SAMPLE: ASIC_Clock=0. ASIC outputs are sampled into buffer[idx], then idx++.
//     - If the word was not the packet's first word and KeepShift & bit are both 1, the error count increments, saturating at 127.
//     - Next state is DRAIN if the word had eop or idx reaches BUF_DEPTH (forced eop); otherwise FILL.
//   - Throughput: 1 input word per 3 clocks. Pins hold their value until the next accepted word.
// - Channel select: bit/DOut/start = bitout1/DOut1/Start when switch_fpga_asic=1, else bitout2/DOut2/Start2.
// - Output word map:
//   - [29] TestReady; [27] start; [26] KeepShift; [25] Dclk; [24] bit; [22:16] TOut; [14:8] DOut.
//   - [6:0] final error count of the packet, identical in every word. All other bits are 0.
// - DRAIN: asi_ready=0. Words 0..n-1 are presented in order with aso_valid=1.
//   - aso_sop is high on word 0; aso_eop is high on word n-1; a 1-word packet has both.
//   - Advance only on aso_valid & aso_ready; data and sop/eop stay stable while stalled.
//   - After eop is accepted: FILL, packet closed.
// - Reset at any point aborts the packet, drops the buffer and returns to FILL.
// TESTING
// - 202-word packet; ASIC model asserts KeepShift=bitout1=1 on words 10..14 -> 202 out words, sop on word 0, eop on word 201, [6:0]=5 in every word incl. word 3.
// - Same packet with aso_ready random 50% and random asi_valid gaps -> no loss/duplication, order kept, sop/eop stable while stalled.
// - Word 0x0000_7E55 (packet open) -> ASIC_In=0x55, Go=0, S3..S1=1, Sel_f=1, Enable_f=1, Mode=1; exactly one ASIC_Clock pulse.
// - switch_fpga_asic=0, bitout2=1, DOut2=0x2A, Start2=1 -> out [24]=1, [14:8]=0x2A, [27]=1.
// - reset asserted after 50 words of a packet -> all outputs 0, no out packet; next full packet correct.
// - 150 error words (BUF_DEPTH=256) -> error field saturates at 127. Words sent before any sop -> dropped, no ASIC_Clock.

Source files
------------

// File: rtl/turbo_asic_avalon.sv
// Avalon-ST to turbo-decoder test ASIC bridge: each input word drives the pins, pulses ASIC_Clock and samples results.
// A finished packet is replayed as one Avalon-ST packet, and every word carries the packet's saturating bit-error count.
module turbo_asic_avalon #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 256,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] asi_data,
  input  logic                  asi_valid,
  output logic                  asi_ready,
  input  logic                  asi_sop,
  input  logic                  asi_eop,
  output logic [DATA_WIDTH-1:0] aso_data,
  output logic                  aso_valid,
  input  logic                  aso_ready,
  output logic                  aso_sop,
  output logic                  aso_eop,
  input  logic                  switch_fpga_asic,
  output logic                  ASIC_nReset,
  output logic                  ASIC_Clock,
  output logic                  ASIC_Go,
  output logic                  ASIC_Mode,
  output logic                  ASIC_Enable_f,
  output logic                  ASIC_Sel_f,
  output logic                  ASIC_S1,
  output logic                  ASIC_S2,
  output logic                  ASIC_S3,
  output logic [6:0]            ASIC_In,
  input  logic [6:0]            ASIC_DOut1,
  input  logic [6:0]            ASIC_DOut2,
  input  logic [6:0]            ASIC_TOut,
  input  logic                  ASIC_bitout1,
  input  logic                  ASIC_bitout2,
  input  logic                  ASIC_KeepShift,
  input  logic                  ASIC_Start,
  input  logic                  ASIC_Start2,
  input  logic                  ASIC_TestReady,
  input  logic                  ASIC_Dclk
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int EW = 19;

  typedef enum logic [1:0] {FILL, CLK_HI, SAMPLE, DRAIN} state_t;

  state_t                 state_q;
  logic                   open_q, eop_q, rdy_q, vld_q, osop_q, oeop_q;
  logic                   nrst_q, clk_q, go_q, mode_q, en_q, sel_q, s1_q, s2_q, s3_q;
  logic [6:0]             in_q;
  logic [LW-1:0]          idx_q, rd_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [EW-1:0]          buf_q [BUF_DEPTH];
  logic [EW-1:0]          samp_d, rd_ent;
  logic                   bit_sel, err_d, last_d;
  logic [31:0]            word;
  logic                   unused_ok;

  // Entry layout: {TestReady, start, KeepShift, Dclk, bit, TOut, DOut}
  assign bit_sel = switch_fpga_asic ? ASIC_bitout1 : ASIC_bitout2;
  assign samp_d  = {ASIC_TestReady, switch_fpga_asic ? ASIC_Start : ASIC_Start2,
                    ASIC_KeepShift, ASIC_Dclk, bit_sel, ASIC_TOut,
                    switch_fpga_asic ? ASIC_DOut1 : ASIC_DOut2};
  assign err_d   = (idx_q != '0) && ASIC_KeepShift && bit_sel && (cnt_q != {CNT_WIDTH{1'b1}});
  assign last_d  = eop_q || (idx_q + LW'(1) == LW'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      open_q  <= 1'b0;
      eop_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      nrst_q  <= 1'b0;
      clk_q   <= 1'b0;
      go_q    <= 1'b0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      in_q    <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      nrst_q <= 1'b1;
      case (state_q)
        FILL: begin
          rdy_q <= 1'b1;
          // Words arriving with no packet open are consumed silently.
          if (asi_valid && rdy_q && (asi_sop || open_q)) begin
            if (asi_sop) begin
              open_q <= 1'b1;
              idx_q  <= '0;
              cnt_q  <= '0;
            end
            in_q    <= asi_data[6:0];
            go_q    <= asi_data[8];
            s3_q    <= asi_data[9];
            s2_q    <= asi_data[10];
            s1_q    <= asi_data[11];
            sel_q   <= asi_data[12];
            en_q    <= asi_data[13];
            mode_q  <= asi_data[14];
            eop_q   <= asi_eop;
            clk_q   <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= CLK_HI;
          end
        end
        CLK_HI: begin
          clk_q   <= 1'b0;
          state_q <= SAMPLE;
        end
        SAMPLE: begin
          idx_q <= idx_q + LW'(1);
          if (err_d) cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (last_d) begin
            vld_q   <= 1'b1;
            osop_q  <= 1'b1;
            oeop_q  <= (idx_q == '0);
            rd_q    <= '0;
            state_q <= DRAIN;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= FILL;
          end
        end
        default: begin
          if (aso_ready) begin
            if (oeop_q) begin
              vld_q   <= 1'b0;
              oeop_q  <= 1'b0;
              osop_q  <= 1'b0;
              open_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= FILL;
            end else begin
              rd_q   <= rd_q + LW'(1);
              osop_q <= 1'b0;
              oeop_q <= (rd_q + LW'(2) == idx_q);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == SAMPLE) buf_q[idx_q[AW-1:0]] <= samp_d;
  end

  assign rd_ent = buf_q[rd_q[AW-1:0]];
  // The count register already holds the packet's final value throughout the drain.
  always_comb word = {2'b00, rd_ent[18], 1'b0, rd_ent[17:14], 1'b0, rd_ent[13:7],
                      1'b0, rd_ent[6:0], 1'b0, 7'(cnt_q)};

  assign aso_data      = vld_q ? DATA_WIDTH'(word) : '0;
  assign aso_valid     = vld_q;
  assign aso_sop       = osop_q;
  assign aso_eop       = oeop_q;
  assign asi_ready     = rdy_q;
  assign ASIC_nReset   = nrst_q;
  assign ASIC_Clock    = clk_q;
  assign ASIC_Go       = go_q;
  assign ASIC_Mode     = mode_q;
  assign ASIC_Enable_f = en_q;
  assign ASIC_Sel_f    = sel_q;
  assign ASIC_S1       = s1_q;
  assign ASIC_S2       = s2_q;
  assign ASIC_S3       = s3_q;
  assign ASIC_In       = in_q;

  assign unused_ok = ^{asi_data[DATA_WIDTH-1:15], asi_data[7]};
endmodule

// File: tb/tb_turbo_asic_avalon.sv
// Bench for turbo_asic_avalon: reactive ASIC model, random stimulus, reference built from per-word pin tables.
module tb_turbo_asic_avalon;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] asi_data = '0;
  logic        asi_valid = 1'b0, asi_sop = 1'b0, asi_eop = 1'b0;
  logic        asi_ready;
  logic [31:0] aso_data;
  logic        aso_valid, aso_sop, aso_eop;
  logic        aso_ready = 1'b1;
  logic        switch_fpga_asic = 1'b1;
  logic        ASIC_nReset, ASIC_Clock, ASIC_Go, ASIC_Mode, ASIC_Enable_f, ASIC_Sel_f;
  logic        ASIC_S1, ASIC_S2, ASIC_S3;
  logic [6:0]  ASIC_In;
  logic [6:0]  ASIC_DOut1 = '0, ASIC_DOut2 = '0, ASIC_TOut = '0;
  logic        ASIC_bitout1 = 0, ASIC_bitout2 = 0, ASIC_KeepShift = 0, ASIC_Start = 0;
  logic        ASIC_Start2 = 0, ASIC_TestReady = 0, ASIC_Dclk = 0;

  always #5 clk = ~clk;

  turbo_asic_avalon dut (
    .clk(clk), .reset(reset),
    .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
    .asi_sop(asi_sop), .asi_eop(asi_eop),
    .aso_data(aso_data), .aso_valid(aso_valid), .aso_ready(aso_ready),
    .aso_sop(aso_sop), .aso_eop(aso_eop),
    .switch_fpga_asic(switch_fpga_asic),
    .ASIC_nReset(ASIC_nReset), .ASIC_Clock(ASIC_Clock), .ASIC_Go(ASIC_Go),
    .ASIC_Mode(ASIC_Mode), .ASIC_Enable_f(ASIC_Enable_f), .ASIC_Sel_f(ASIC_Sel_f),
    .ASIC_S1(ASIC_S1), .ASIC_S2(ASIC_S2), .ASIC_S3(ASIC_S3), .ASIC_In(ASIC_In),
    .ASIC_DOut1(ASIC_DOut1), .ASIC_DOut2(ASIC_DOut2), .ASIC_TOut(ASIC_TOut),
    .ASIC_bitout1(ASIC_bitout1), .ASIC_bitout2(ASIC_bitout2),
    .ASIC_KeepShift(ASIC_KeepShift), .ASIC_Start(ASIC_Start), .ASIC_Start2(ASIC_Start2),
    .ASIC_TestReady(ASIC_TestReady), .ASIC_Dclk(ASIC_Dclk)
  );

  // Per-word ASIC response tables, indexed by word position within the packet.
  logic [6:0] m_d1 [256], m_d2 [256], m_t [256];
  logic       m_b1 [256], m_b2 [256], m_keep [256], m_st1 [256], m_st2 [256];
  logic       m_tr [256], m_dclk [256];
  int         pulse_cnt = 0;
  int         base = 0;

  always @(posedge ASIC_Clock) begin
    int k;
    k = (pulse_cnt - base) & 255;
    ASIC_DOut1 = m_d1[k];  ASIC_DOut2 = m_d2[k];  ASIC_TOut = m_t[k];
    ASIC_bitout1 = m_b1[k]; ASIC_bitout2 = m_b2[k]; ASIC_KeepShift = m_keep[k];
    ASIC_Start = m_st1[k]; ASIC_Start2 = m_st2[k]; ASIC_TestReady = m_tr[k];
    ASIC_Dclk = m_dclk[k];
    pulse_cnt = pulse_cnt + 1;
  end

  int errors = 0, checks = 0, to_cnt = 0, stall_bad = 0;
  logic [31:0] rq_dat [$];
  logic        rq_sop [$], rq_eop [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: errors only on words 10..14; 1: every word errors; 2: random; 3: channel-2 fixed pattern
  task automatic gen_pkt(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      m_d1[k] = 7'($urandom); m_d2[k] = 7'($urandom); m_t[k] = 7'($urandom);
      m_st1[k] = 1'($urandom); m_st2[k] = 1'($urandom); m_tr[k] = 1'($urandom);
      m_dclk[k] = 1'($urandom); m_b2[k] = 1'($urandom);
      m_keep[k] = 1'($urandom); m_b1[k] = 1'($urandom);
      if (mode == 0) begin
        m_b1[k] = (k >= 10 && k <= 14) ? 1'b1 : ~m_keep[k];
        if (k >= 10 && k <= 14) m_keep[k] = 1'b1;
      end else if (mode == 1) begin
        m_keep[k] = 1'b1; m_b1[k] = 1'b1;
      end else if (mode == 3) begin
        m_b2[k] = 1'b1; m_d2[k] = 7'h2A; m_st2[k] = 1'b1;
      end
    end
  endtask

  function automatic int exp_cnt(input int n, input bit sw);
    int c = 0;
    for (int k = 1; k < n; k++)
      if (m_keep[k] && (sw ? m_b1[k] : m_b2[k])) c++;
    return (c > 127) ? 127 : c;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input bit sw, input int cnt);
    int b, st, d;
    b  = sw ? int'(m_b1[k]) : int'(m_b2[k]);
    st = sw ? int'(m_st1[k]) : int'(m_st2[k]);
    d  = sw ? int'(m_d1[k]) : int'(m_d2[k]);
    return 32'(int'(m_tr[k]) * (1 << 29) + st * (1 << 27) + int'(m_keep[k]) * (1 << 26)
             + int'(m_dclk[k]) * (1 << 25) + b * (1 << 24) + int'(m_t[k]) * (1 << 16)
             + d * (1 << 8) + cnt);
  endfunction

  task automatic send_word(input logic [31:0] d, input logic s, input logic e, input int maxgap);
    int b = 0;
    repeat ((maxgap > 0) ? $urandom_range(maxgap, 0) : 0) @(negedge clk);
    asi_data = d; asi_sop = s; asi_eop = e; asi_valid = 1'b1;
    while (!asi_ready && b < 1000) begin @(negedge clk); b++; end
    if (!asi_ready) to_cnt++;
    @(negedge clk);
    asi_valid = 1'b0; asi_sop = 1'b0; asi_eop = 1'b0;
  endtask

  task automatic sender(input int n, input int maxgap, input bit fixed, input logic [31:0] fdat);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      d = fixed ? fdat : $urandom;
      d[24] = (k == 0); d[25] = (k == n - 1);
      send_word(d, k == 0, k == n - 1, maxgap);
    end
  endtask

  task automatic receiver(input bit rnd);
    bit st = 0, done = 0;
    logic [31:0] sd; logic ss, se;
    int cyc = 0;
    while (!done && cyc < 10000) begin
      @(negedge clk); cyc++;
      if (st && !(aso_valid && aso_data === sd && aso_sop === ss && aso_eop === se)) stall_bad++;
      aso_ready = rnd ? 1'($urandom) : 1'b1;
      st = aso_valid && !aso_ready; sd = aso_data; ss = aso_sop; se = aso_eop;
      if (aso_valid && aso_ready) begin
        rq_dat.push_back(aso_data); rq_sop.push_back(aso_sop); rq_eop.push_back(aso_eop);
        if (aso_eop) done = 1;
      end
    end
    if (!done) to_cnt++;
    aso_ready = 1'b1;
  endtask

  task automatic run_packet(input string tag, input int n, input bit sw, input int maxgap,
                            input bit rnd, input bit fixed, input logic [31:0] fdat);
    int mism = 0, ec;
    switch_fpga_asic = sw;
    base = pulse_cnt;
    stall_bad = 0;
    rq_dat.delete(); rq_sop.delete(); rq_eop.delete();
    fork
      sender(n, maxgap, fixed, fdat);
      receiver(rnd);
    join
    ec = exp_cnt(n, sw);
    chk({tag, "_len"}, rq_dat.size(), n);
    for (int k = 0; k < rq_dat.size() && k < n; k++)
      if (rq_dat[k] !== exp_word(k, sw, ec) || rq_sop[k] !== (k == 0) || rq_eop[k] !== (k == n - 1))
        mism++;
    chk({tag, "_words"}, mism, 0);
    chk({tag, "_pulses"}, pulse_cnt - base, n);
    chk({tag, "_stall"}, stall_bad, 0);
    chk({tag, "_timeout"}, to_cnt, 0);
  endtask

  initial begin
    int vseen;
    repeat (3) @(negedge clk);
    chk("rst_nreset", ASIC_nReset, 0);
    chk("rst_ready", asi_ready, 0);
    chk("rst_valid", aso_valid, 0);
    chk("rst_data", aso_data, 0);
    chk("rst_pins", {ASIC_Clock, ASIC_Go, ASIC_Mode, ASIC_Enable_f, ASIC_Sel_f,
                     ASIC_S1, ASIC_S2, ASIC_S3, ASIC_In, aso_sop, aso_eop}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("nreset_rel", ASIC_nReset, 1);

    // Words before any sop are consumed without touching the ASIC.
    for (int k = 0; k < 3; k++) send_word($urandom & 32'hFEFF_FFFF, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("drop_pulses", pulse_cnt, 0);
    chk("drop_noout", aso_valid, 0);

    gen_pkt(202, 0);
    run_packet("pktA", 202, 1'b1, 0, 1'b0, 1'b0, '0);
    chk("pktA_w3cnt", rq_dat[3][6:0], 5);
    chk("pktA_sopeop", {rq_sop[0], rq_eop[201], rq_eop[200]}, 3'b110);

    run_packet("pktB", 202, 1'b1, 3, 1'b1, 1'b0, '0);

    gen_pkt(1, 2);
    run_packet("pins", 1, 1'b1, 0, 1'b0, 1'b1, 32'h0000_7E55);
    chk("pins_in", ASIC_In, 7'h55);
    chk("pins_ctl", {ASIC_Go, ASIC_S3, ASIC_S2, ASIC_S1, ASIC_Sel_f, ASIC_Enable_f, ASIC_Mode}, 7'b0111111);
    chk("pins_1word", {rq_sop[0], rq_eop[0]}, 2'b11);

    gen_pkt(4, 3);
    run_packet("ch2", 4, 1'b0, 1, 1'b1, 1'b0, '0);
    chk("ch2_fields", {rq_dat[0][27], rq_dat[0][24], 1'b0, rq_dat[0][14:8]}, {2'b11, 8'h2A});

    // Abort a packet mid-way with reset.
    gen_pkt(202, 2);
    base = pulse_cnt;
    for (int k = 0; k < 50; k++) send_word($urandom, k == 0, 1'b0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outs", {ASIC_nReset, ASIC_Clock, ASIC_Go, ASIC_Mode, ASIC_Enable_f, ASIC_Sel_f,
                       ASIC_S1, ASIC_S2, ASIC_S3, ASIC_In, aso_valid, asi_ready, aso_sop, aso_eop}, 0);
    chk("abort_data", aso_data, 0);
    reset = 1'b0;
    vseen = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (aso_valid) vseen++; end
    chk("abort_noout", vseen, 0);
    chk("abort_pulses", pulse_cnt - base, 50);
    run_packet("afterAbort", 202, 1'b1, 2, 1'b1, 1'b0, '0);

    gen_pkt(150, 1);
    run_packet("sat", 150, 1'b1, 0, 1'b0, 1'b0, '0);
    chk("sat_cnt", rq_dat[149][6:0], 127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
